// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one uart_tx among NUM_REQ byte producers; `define ARB_TIMEOUT_EN adds an idle-lock release timer
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int PTR_W       = 3,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     pkt_done,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   timeout_flag
);
  typedef enum logic [2:0] {IDLE, HOLD, START, WAIT_ACK, WAIT_DONE} state_t;
  localparam logic [PTR_W:0] N = (PTR_W+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = 1;
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [PTR_W-1:0] g_idx, g_idx_n, rr_ptr, rr_ptr_n, pick;
  logic [7:0] tx_data_n, sel_data;
  logic last_r, last_n, sel_valid, sel_last, accept;
  function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W:0] v);
    return (v >= N) ? PTR_W'(v - N) : PTR_W'(v);
  endfunction
  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    pick = rr_ptr;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (|(req_valid & (ONE << wrap({1'b0, rr_ptr} + (PTR_W+1)'(k)))))
        pick = wrap({1'b0, rr_ptr} + (PTR_W+1)'(k));
  end
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      sel_data = sel_data | (grant[i] ? req_data[8*i +: 8] : 8'h00);
  end
  assign sel_valid = |(req_valid & grant);
  assign sel_last  = |(req_last & grant);
  assign accept    = (state == HOLD) && sel_valid && !tx_busy;
  assign req_ready = accept ? grant : '0;
  assign pkt_done  = (state == WAIT_DONE && !tx_busy && last_r) ? grant : '0;
  assign tx_start  = (state == START);
`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic flag_n;
`endif
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    g_idx_n   = g_idx;
    rr_ptr_n  = rr_ptr;
    tx_data_n = tx_data;
    last_n    = last_r;
    case (state)
      IDLE: if (|req_valid) begin
        state_n = HOLD;
        grant_n = ONE << pick;
        g_idx_n = pick;
      end
      HOLD: if (accept) begin
        state_n   = START;
        tx_data_n = sel_data;
        last_n    = sel_last;
      end
      START:    state_n = WAIT_ACK;
      WAIT_ACK: state_n = tx_busy ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: if (!tx_busy) begin
        state_n  = last_r ? IDLE : HOLD;
        grant_n  = last_r ? '0 : grant;
        rr_ptr_n = last_r ? wrap({1'b0, g_idx} + 1'b1) : rr_ptr;
      end
      default: state_n = IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    cnt_n  = cnt;
    flag_n = timeout_flag;
    if (state == IDLE || accept)
      cnt_n = '0;
    else if (state == HOLD && !sel_valid) begin
      cnt_n = cnt + 1'b1;
      if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_n  = IDLE;
        grant_n  = '0;
        rr_ptr_n = wrap({1'b0, g_idx} + 1'b1);
        flag_n   = 1'b1;
        cnt_n    = '0;
      end
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      g_idx   <= '0;
      rr_ptr  <= '0;
      tx_data <= 8'h00;
      last_r  <= 1'b0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      g_idx   <= g_idx_n;
      rr_ptr  <= rr_ptr_n;
      tx_data <= tx_data_n;
      last_r  <= last_n;
    end
  end
`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      timeout_flag <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      timeout_flag <= flag_n;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif
endmodule
